// File: rtl/multiply_tokens_pkg.sv
// rtl/multiply_tokens_pkg.sv - shared constants and helpers for the token multiplier
package multiply_tokens_pkg;

    localparam int MULT_W_DEF = 3;
    localparam int CNT_W_DEF  = 8;

    // Largest value representable in a cnt_w-bit counter
    function automatic logic [31:0] sat_max(input int cnt_w);
        return (32'd1 << cnt_w) - 32'd1;
    endfunction

endpackage

// File: rtl/multiply_tokens_sat_up_down_counter.sv
// rtl/multiply_tokens_sat_up_down_counter.sv - saturating pending-token counter
module sat_up_down_counter
    import multiply_tokens_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] add,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             sat_pulse
);

    localparam logic [CNT_W:0] MAX = (CNT_W + 1)'(sat_max(CNT_W));

    logic [CNT_W:0] sum;

    // One extra bit of headroom: count + add - dec never goes negative and
    // never exceeds 2*MAX, so the top bit cleanly flags saturation.
    always_comb begin
        sum       = {1'b0, count} + {1'b0, add} - {{CNT_W{1'b0}}, dec};
        sat_pulse = (sum > MAX);
    end

    // Count register clamps at MAX instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (sat_pulse) begin
            count <= MAX[CNT_W-1:0];
        end else begin
            count <= sum[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/multiply_tokens.sv
// rtl/multiply_tokens.sv - token-rate multiplier with back-pressure and sticky overflow
module multiply_tokens
    import multiply_tokens_pkg::*;
#(
    parameter int MULT_W = MULT_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a,
    input  logic [MULT_W-1:0] mult,
    input  logic              b_ready,
    input  logic              clear_overflow,
    output logic              b,
    output logic [CNT_W-1:0]  pending,
    output logic              overflow
);

    logic [CNT_W-1:0] add;
    logic             sat_pulse;

    // mult is masked when no token arrives so an undriven factor cannot leak.
    // b is forced low during reset because a bypass token could otherwise
    // emit while the counter is held at zero.
    always_comb begin
        add = a ? CNT_W'(mult) : '0;
        b   = rst_n & b_ready & ((pending != '0) | (add != '0));
    end

    sat_up_down_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .add       (add),
        .dec       (b),
        .count     (pending),
        .sat_pulse (sat_pulse)
    );

    // Sticky overflow; a saturation in the same cycle as a clear keeps it set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (sat_pulse) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_multiply_tokens.sv
// tb/tb_multiply_tokens.sv - directed self-checking bench for multiply_tokens
module tb_multiply_tokens;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a;
    logic [2:0] mult;
    logic       b_ready;
    logic       clear_overflow;
    logic       b;
    logic [7:0] pending;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    multiply_tokens #(.MULT_W(3), .CNT_W(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .a              (a),
        .mult           (mult),
        .b_ready        (b_ready),
        .clear_overflow (clear_overflow),
        .b              (b),
        .pending        (pending),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nb;
        int summ;
        int wraps;
        logic [7:0] prev;

        rst_n = 1'b0; a = 1'b0; mult = '0; b_ready = 1'b0; clear_overflow = 1'b0;
        #12;
        check("reset_pending", 32'(pending), 0);
        check("reset_overflow", 32'(overflow), 0);
        a = 1'b1; mult = 3'd3; b_ready = 1'b1;
        #1;
        check("reset_b_gated", 32'(b), 0);
        a = 1'b0; mult = '0;
        #1;
        rst_n = 1'b1;
        cycle();

        // single token, mult=3, zero-latency bypass
        a = 1'b1; mult = 3'd3; b_ready = 1'b1;
        #1;
        check("single_b0", 32'(b), 1);
        cycle();
        check("single_p2", 32'(pending), 2);
        a = 1'b0; mult = 3'd5;
        #1;
        check("single_b1", 32'(b), 1);
        cycle();
        check("single_p1", 32'(pending), 1);
        check("single_b2", 32'(b), 1);
        cycle();
        check("single_p0", 32'(pending), 0);
        check("single_b_idle", 32'(b), 0);
        check("single_ovf", 32'(overflow), 0);

        // back-pressure: 4 tokens x2 while stalled, then drain 8
        b_ready = 1'b0;
        nb = 0;
        for (int i = 0; i < 4; i++) begin
            a = 1'b1; mult = 3'd2;
            #1;
            if (b) nb++;
            cycle();
        end
        a = 1'b0;
        #1;
        check("bp_stalled_b", 32'(nb), 0);
        check("bp_pending8", 32'(pending), 8);
        b_ready = 1'b1;
        nb = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (b) nb++;
            cycle();
        end
        check("bp_drain_count", 32'(nb), 8);
        check("bp_drained", 32'(pending), 0);

        // random conservation
        nb = 0; summ = 0;
        for (int i = 0; i < 100; i++) begin
            a = ($urandom_range(99) < 30);
            mult = 3'($urandom_range(7));
            b_ready = ($urandom_range(99) < 70);
            #1;
            if (b) nb++;
            if (a) summ += int'(mult);
            cycle();
        end
        a = 1'b0; b_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (b) nb++;
            cycle();
        end
        check("rand_conservation", 32'(nb), 32'(summ));
        check("rand_pending", 32'(pending), 0);
        check("rand_ovf", 32'(overflow), 0);

        // mult=0 continuous
        nb = 0;
        a = 1'b1; mult = 3'd0; b_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (b) nb++;
            cycle();
        end
        check("mult0_no_b", 32'(nb), 0);
        check("mult0_pending", 32'(pending), 0);

        // mult=1 continuous
        nb = 0;
        mult = 3'd1;
        for (int i = 0; i < 1000; i++) begin
            #1;
            if (b) nb++;
            cycle();
        end
        check("mult1_b_every", 32'(nb), 1000);
        check("mult1_pending", 32'(pending), 0);
        check("mult1_ovf", 32'(overflow), 0);

        // saturation: grows by 6 per cycle, 252 after 42 cycles, clamps on the 43rd
        mult = 3'd7;
        wraps = 0;
        prev = pending;
        for (int i = 0; i < 42; i++) begin
            cycle();
            if (pending < prev) wraps++;
            prev = pending;
        end
        check("sat_p252", 32'(pending), 252);
        check("sat_ovf_before", 32'(overflow), 0);
        for (int i = 0; i < 958; i++) begin
            cycle();
            if (pending < prev) wraps++;
            prev = pending;
        end
        check("sat_no_wrap", 32'(wraps), 0);
        check("sat_p255", 32'(pending), 255);
        check("sat_ovf_set", 32'(overflow), 1);

        // clear with no token
        a = 1'b0; b_ready = 1'b0; clear_overflow = 1'b1;
        cycle();
        clear_overflow = 1'b0;
        check("clear_ovf", 32'(overflow), 0);
        check("clear_hold_p", 32'(pending), 255);

        // clear in the same cycle as saturation: set wins
        a = 1'b1; mult = 3'd7; b_ready = 1'b1; clear_overflow = 1'b1;
        cycle();
        clear_overflow = 1'b0; a = 1'b0;
        check("set_wins_ovf", 32'(overflow), 1);
        check("set_wins_p", 32'(pending), 255);

        // drain 215 to reach 40, overflow still sticky
        for (int i = 0; i < 215; i++) cycle();
        check("pre_rst_p40", 32'(pending), 40);
        check("pre_rst_ovf", 32'(overflow), 1);

        // asynchronous reset between edges
        b_ready = 1'b0;
        #3;
        rst_n = 1'b0;
        b_ready = 1'b1;
        #1;
        check("async_rst_p", 32'(pending), 0);
        check("async_rst_ovf", 32'(overflow), 0);
        check("async_rst_b", 32'(b), 0);
        cycle();
        #2;
        rst_n = 1'b1;
        cycle();

        // one token x2 after release
        nb = 0;
        a = 1'b1; mult = 3'd2; b_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (b) nb++;
            cycle();
            a = 1'b0;
        end
        check("post_rst_b_count", 32'(nb), 2);
        check("post_rst_pending", 32'(pending), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multiply_tokens.md
Name: multiply_tokens

Overview:
- Token-rate multiplier: every token (single-cycle pulse) on `a` produces `mult` output tokens on `b`, one per accepted output cycle.
- Parametrised successor of the fixed ×2 token doubler: the multiplier factor is runtime-selectable, the pending-token counter width is a parameter, and output back-pressure is supported.
- Sits between a token producer and a credit/ready consumer in the sequential-basics datapath.
- Overflow is sticky, software-clearable, and never silently wraps.

Parameters:
- `MULT_W`, default 3: width of the `mult` factor; factors 0..2^MULT_W-1.
- `CNT_W`, default 8: width of the pending-token counter; max pending = 2^CNT_W-1. Must satisfy `CNT_W >= MULT_W`.

Ports:
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `a`  in  1  input token; one token per cycle when high; always accepted.
- `mult`  in  MULT_W  multiplier factor, sampled only in cycles where `a`=1.
- `b_ready`  in  1  downstream ready; an output token is transferred when `b`=1.
- `clear_overflow`  in  1  synchronous pulse; clears sticky `overflow`.
- `b`  out  1  output token (valid and accepted this cycle).
- `pending`  out  CNT_W  registered count of tokens owed but not yet emitted.
- `overflow`  out  1  sticky flag; set when owed tokens were lost to saturation.

Behaviour:
- Reset (`rst_n`=0, asynchronous, any time including mid-burst):
  - `pending`=0, `overflow`=0 immediately.
  - `b`=0 while reset is asserted.
  - Owed tokens are discarded.
- Combinational output: `b = b_ready & ((pending != 0) | (a & (mult != 0)))`.
  - Zero-latency bypass: a token with `mult`>=1 arriving at `pending`=0 with `b_ready`=1 emits its first output token in the same cycle.
- Add term: `add = a ? mult : 0`, zero-extended to CNT_W+1 bits.
- Next count: `sum = pending + add - b`, computed in CNT_W+1 bits. `sum` is never negative, since `b`=1 implies `pending`>0 or `add`>0.
- Saturation: if `sum > 2^CNT_W-1`, then `pending` <= 2^CNT_W-1 and `overflow` <= 1. Otherwise `pending` <= `sum`.
- Overflow flag:
  - `clear_overflow` clears `overflow` next cycle.
  - If saturation and `clear_overflow` occur in the same cycle, set wins (`overflow` stays 1).
- Edge cases:
  - `mult`=0: the token is consumed with no output and no `pending` change.
  - `b_ready`=0: `pending` only accumulates; `b` stays 0.
- Conservation invariant, with no saturation since reset:
  - Σ `b` over the run = Σ `mult` over tokens − `pending`.
  - After idle drain (`a`=0, `b_ready`=1 for `pending` cycles), `pending`=0.
- Steady state: `b` is high every cycle while `pending`>0 and `b_ready`=1. Drain rate is 1 token/cycle.
- Overflow stress: with `mult`>=2, continuous `a`=1 and `b_ready`=1, `pending` grows by `mult`-1 per cycle and eventually saturates.
  - `mult`=1 with continuous `a` never overflows.
- No X propagation: `mult` is ignored (masked) when `a`=0.

Decomposition:
- Package `multiply_tokens_pkg`:
  - Default constants `MULT_W_DEF`=3, `CNT_W_DEF`=8.
  - Helper function `sat_max(CNT_W)` returning 2^CNT_W-1.
- Natural sub-module: `sat_up_down_counter`.
  - Parameter: CNT_W.
  - Inputs: `add` [CNT_W-1:0], `dec` (1 bit).
  - Outputs: `count`, `sat_pulse`.
  - Asynchronous active-low reset.
- Top level holds the `b` logic and the sticky overflow register.

Test Plan:
- Reset then single token:
  - Stimulus: `a`=1, `mult`=3, `b_ready`=1 for one cycle, then `a`=0.
  - Response: `b`=1 for exactly 3 consecutive cycles starting in the `a` cycle; `pending` sequence 2,1,0; `overflow`=0.
- Back-pressure:
  - Stimulus: `b_ready`=0; 4 tokens with `mult`=2; then `b_ready`=1.
  - Response: `pending`=8 and `b`=0 while stalled; then 8 consecutive `b` pulses and `pending`=0.
- Random conservation (bench as in the doubler test, with random `mult` and `b_ready`):
  - Stimulus: 100 cycles of random `a` (P=30%), random `mult` 0..7, random `b_ready` (P=70%); then 300 idle cycles with `b_ready`=1.
  - Response: count of `b` == Σ `mult`; `pending`=0; `overflow`=0 (CNT_W=8).
- `mult`=0 and `mult`=1 continuous:
  - Stimulus: `a`=1 for 50 cycles with `mult`=0.
  - Response: no `b`, `pending`=0.
  - Stimulus: then `a`=1 for 1000 cycles with `mult`=1.
  - Response: `b`=1 every cycle; `pending`=0; `overflow`=0.
- Saturation and clear:
  - Stimulus: CNT_W=8, `a`=1, `mult`=7, `b_ready`=1 for 1000 cycles.
  - Response: `pending`=255 and `overflow`=1 at end; `pending` never wraps.
  - Stimulus: then `clear_overflow` pulse with `a`=0.
  - Response: `overflow`=0 next cycle.
  - Stimulus: repeat with `clear_overflow` in the same cycle as saturation.
  - Response: `overflow` stays 1.
- Asynchronous reset mid-burst:
  - Stimulus: `pending`=40, then `rst_n` low between clock edges.
  - Response: `pending`=0, `overflow`=0, `b`=0 before the next edge.
  - Stimulus: after release, one token with `mult`=2.
  - Response: exactly 2 `b` pulses.
